branch_history_table: RTL and testbench

Dynamic branch predictor for the pipelined core: a table of 2-bit saturating counters, indexed by PC, read in fetch and trained in execute. It consumes the branch comparator's result in execute, applies the branch-polarity inversion (BNE/BGE/BGEU), and flags mispredictions against the prediction carried down the pipeline. Redirect and flush logic uses `mispredict` and `actual_taken` to steer the program counter.

---
 rtl/branch_history_table.sv | 136 +++++++++++++
 tb/tb_branch_history_table.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
//
// Dynamic branch predictor. It holds a table of 2-bit saturating counters that
// is indexed by PC[INDEX_BITS+1:2]. Fetch reads the table combinationally.
// Execute trains the table with the resolved branch outcome. Execute also
// applies the comparator polarity inversion (BNE/BGE/BGEU) and flags a
// mispredict against the prediction that travelled down the pipeline.
//
// Optional build macro:
//   BHT_PERF_COUNTERS_EN - adds the branch_count / mispredict_count outputs.
//
// Ports:
//   clk              in   core clock; all state updates on the rising edge
//   reset            in   asynchronous, active-high; clears all state
//   fetch_pc         in   PC of the instruction in fetch
//   predict_taken    out  prediction for fetch_pc (combinational table read)
//   ex_valid         in   a conditional branch retires in execute this cycle
//   ex_pc            in   PC of the branch in execute
//   ex_cmp_out       in   comparator result (EQ/LT/LTU)
//   ex_invert        in   high for BNE/BGE/BGEU
//   ex_predicted     in   predict_taken sampled in fetch for this branch
//   actual_taken     out  ex_cmp_out ^ ex_invert
//   mispredict       out  ex_valid & (actual_taken != ex_predicted)
//   branch_count     out  (BHT_PERF_COUNTERS_EN) retired conditional branches
//   mispredict_count out  (BHT_PERF_COUNTERS_EN) mispredicted branches
// -----------------------------------------------------------------------------
module branch_history_table #(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fetch_pc,
   output logic        predict_taken,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_cmp_out,
   input  logic        ex_invert,
   input  logic        ex_predicted,
   output logic        actual_taken,
   output logic        mispredict
`ifdef BHT_PERF_COUNTERS_EN
   ,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
`endif
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   // Per-entry 2-bit saturating counter. The MSB is the prediction.
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } counter_t;

   counter_t                table_q [ENTRIES];
   logic [INDEX_BITS-1:0]   fetch_idx;
   logic [INDEX_BITS-1:0]   ex_idx;

   // Only the index bits of each PC are used. There are no tags, so PCs that
   // share an index alias to the same counter.
   assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
   assign ex_idx    = ex_pc[INDEX_BITS+1:2];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                             ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

   // One saturating step toward the resolved outcome.
   function automatic counter_t step_counter(input counter_t cur, input logic taken);
      counter_t nxt;
      nxt = cur;
      unique case (cur)
         STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
         default:   nxt = WEAK_NT;
      endcase
      return nxt;
   endfunction

   // ---------------------------------------------------------------------------
   // Execute-side resolution. This logic is independent of the table contents.
   // ---------------------------------------------------------------------------
   always_comb begin
      actual_taken = ex_cmp_out ^ ex_invert;
      mispredict   = ex_valid & (actual_taken != ex_predicted);
   end

   // ---------------------------------------------------------------------------
   // Fetch-side lookup. The read is combinational and has no write bypass, so a
   // same-cycle update to the same index shows up only from the next cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      predict_taken = (table_q[fetch_idx] == WEAK_T) ||
                      (table_q[fetch_idx] == STRONG_T);
   end

   // ---------------------------------------------------------------------------
   // Training. Execute performs at most one update per cycle. Reset has
   // priority over an update that is in flight.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            table_q[i] <= WEAK_NT;
         end
      end else if (ex_valid) begin
         table_q[ex_idx] <= step_counter(table_q[ex_idx], actual_taken);
      end
   end

`ifdef BHT_PERF_COUNTERS_EN
   // ---------------------------------------------------------------------------
   // Performance counters. They wrap modulo 2^32.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (ex_valid) begin
            branch_count <= branch_count + 32'd1;
         end
         if (mispredict) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// -----------------------------------------------------------------------------
// tb_branch_history_table
//
// Directed, self-checking bench for branch_history_table with INDEX_BITS = 6.
// Each step drives the inputs on the falling edge and pushes the expected
// outputs onto a scoreboard queue. The step then pops the entry and compares
// it against the DUT outputs 1 ns later. The perf-counter checks are built
// only when BHT_PERF_COUNTERS_EN is defined.
// -----------------------------------------------------------------------------
module tb_branch_history_table;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_pc;
   logic        predict_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_cmp_out;
   logic        ex_invert;
   logic        ex_predicted;
   logic        actual_taken;
   logic        mispredict;
`ifdef BHT_PERF_COUNTERS_EN
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      string tag;
      logic  pt_only;
      logic  pt;
      logic  act;
      logic  mp;
   } exp_t;

   exp_t sb[$];

   branch_history_table #(.INDEX_BITS(6)) dut (
      .clk              (clk),
      .reset            (reset),
      .fetch_pc         (fetch_pc),
      .predict_taken    (predict_taken),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_cmp_out       (ex_cmp_out),
      .ex_invert        (ex_invert),
      .ex_predicted     (ex_predicted),
      .actual_taken     (actual_taken),
      .mispredict       (mispredict)
`ifdef BHT_PERF_COUNTERS_EN
      ,
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
`endif
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".predict_taken"}, {31'd0, predict_taken}, {31'd0, e.pt});
      if (!e.pt_only) begin
         chk({e.tag, ".actual_taken"}, {31'd0, actual_taken}, {31'd0, e.act});
         chk({e.tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mp});
      end
   endtask

   // Drives one full cycle of inputs on the falling edge and checks all three
   // outputs 1 ns later.
   task automatic step(input string tag, input logic [31:0] fpc, input logic v,
                       input logic [31:0] epc, input logic cmp, input logic inv,
                       input logic pred, input logic e_pt, input logic e_act,
                       input logic e_mp);
      @(negedge clk);
      fetch_pc     = fpc;
      ex_valid     = v;
      ex_pc        = epc;
      ex_cmp_out   = cmp;
      ex_invert    = inv;
      ex_predicted = pred;
      sb.push_back('{tag: tag, pt_only: 1'b0, pt: e_pt, act: e_act, mp: e_mp});
      #1;
      pop_compare();
   endtask

   // Performs a lookup-only check within the current cycle.
   task automatic look(input string tag, input logic [31:0] fpc, input logic e_pt);
      fetch_pc = fpc;
      sb.push_back('{tag: tag, pt_only: 1'b1, pt: e_pt, act: 1'b0, mp: 1'b0});
      #1;
      pop_compare();
   endtask

   initial begin
      reset        = 1'b1;
      fetch_pc     = '0;
      ex_valid     = 1'b0;
      ex_pc        = '0;
      ex_cmp_out   = 1'b0;
      ex_invert    = 1'b0;
      ex_predicted = 1'b0;

      // Reset state. Every entry holds weak-NT.
      @(negedge clk);
      look("rst_pc0", 32'h0, 1'b0);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step("rst_0x0",   32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rst_0x100", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rst_0xffc", 32'hFFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Two taken updates at 0x40: 01 -> 10 -> 11.
      step("tk1_0x40", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("tk2_0x40", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      step("tk_after", 32'h40, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // BNE with equal operands is not taken: 11 -> 10, then 10 -> 01.
      step("bne1",      32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("bne1_after",32'h40, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("bne2",      32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step("bne2_after",32'h40, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Train 0x104 (index 1) to weak-T so that aliasing on index 0 can be
      // shown to leave it alone.
      step("tr_0x104",  32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Five not-taken updates at 0x0: entry saturates at 00.
      for (int i = 0; i < 5; i++) begin
         step($sformatf("nt%0d_0x0", i), 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0);
      end
      step("alias_0x100", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("keep_0x104",  32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // Taken updates through the alias 0x100: 00 -> 01 (NT), then 01 -> 10 (T).
      step("al_tk1", 32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step("al_tk2", 32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step("al_chk", 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Saturation at 11 on 0xC0: four taken, then two not-taken -> 01.
      for (int i = 0; i < 4; i++) begin
         step($sformatf("st%0d_0xc0", i), 32'hC0, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b1,
              (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      end
      step("st_nt1", 32'hC0, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("st_nt2", 32'hC0, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("st_end", 32'hC0, 1'b0, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Same-cycle read/write at 0x80 returns the pre-update value.
      step("hz_upd",  32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("hz_next", 32'h80, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("hz_hold", 32'h80, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // One not-taken step returns the entry to 01, which shows that ex_valid=0
      // did not advance it past 10.
      step("hz_nt",   32'h80, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step("hz_end",  32'h80, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset during a pending taken update at 0x104.
      step("ar_pend", 32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      look("ar_0x104", 32'h104, 1'b0);
      look("ar_0x0",   32'h0,   1'b0);
      @(negedge clk);
      reset    = 1'b0;
      ex_valid = 1'b0;
      look("ar_after", 32'h104, 1'b0);
      // The entry restarts at 01, so one taken step reaches 10.
      step("ar_tk",  32'h104, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("ar_chk", 32'h104, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef BHT_PERF_COUNTERS_EN
      // Ten branches, of which three are mispredicted. Lookup uses an index
      // that is never trained.
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      chk("pc_reset_br", branch_count, 32'd0);
      chk("pc_reset_mp", mispredict_count, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("pc_br%0d", i), 32'h3F0, 1'b1, 32'h200, 1'b1, 1'b0,
              (i < 3) ? 1'b0 : 1'b1, 1'b0, 1'b1, (i < 3) ? 1'b1 : 1'b0);
      end
      step("pc_idle", 32'h3F0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pc_branch_count", branch_count, 32'd10);
      chk("pc_mispredict_count", mispredict_count, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("pc_async_br", branch_count, 32'd0);
      chk("pc_async_mp", mispredict_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
`endif

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
